// File: rtl/rf_pkg.sv
// Shared register-file constants used by the writeback arbiter and related blocks.
package rf_pkg;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned RA_W     = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_ZERO = 0;
    localparam logic [31:0] SP_RESET = 32'h2ffc;

    function automatic logic is_zero_reg(input logic [RA_W-1:0] rd);
        return rd == RA_W'(REG_ZERO);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from the pointer, pointer moves past
// the winner only when the grant is accepted.
module rr_arbiter #(
    parameter int unsigned N_SRC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] i_req,
    input  logic             i_accept,
    output logic [N_SRC-1:0] o_grant
);
    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_d;
    logic [PTR_W-1:0] w_win;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_k;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        w_win   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_k     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(i);
            if (w_sum >= (PTR_W + 1)'(N_SRC)) begin
                w_sum = w_sum - (PTR_W + 1)'(N_SRC);
            end
            w_k = w_sum[PTR_W-1:0];
            if (!w_found && i_req[w_k]) begin
                o_grant[w_k] = 1'b1;
                w_win        = w_k;
                w_found      = 1'b1;
            end
        end
    end

    always_comb begin
        w_ptr_d = r_ptr;
        if (i_accept && w_found) begin
            w_ptr_d = (w_win == PTR_W'(N_SRC - 1)) ? '0 : w_win + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback sources and tracks per-register
// busy bits so decode can stall on RAW/WAW hazards.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned XLEN  = rf_pkg::XLEN,
    parameter int unsigned RA_W  = rf_pkg::RA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      src_valid,
    input  logic [N_SRC*RA_W-1:0] src_rd,
    input  logic [N_SRC*XLEN-1:0] src_data,
    output logic [N_SRC-1:0]      src_ready,
    input  logic                  rsv_valid,
    input  logic [RA_W-1:0]       rsv_rd,
    output logic                  rsv_ready,
    input  logic [RA_W-1:0]       q_rs1,
    input  logic [RA_W-1:0]       q_rs2,
    output logic                  q_stall,
    output logic [31:0]           busy_vec,
    output logic                  rf_we,
    output logic [RA_W-1:0]       rf_rd,
    output logic [XLEN-1:0]       rf_din
);
    logic [N_SRC-1:0] w_grant;
    logic             w_hs;
    logic [RA_W-1:0]  w_sel_rd;
    logic [XLEN-1:0]  w_sel_data;
    logic             w_set;
    logic [31:0]      w_busy_d;

    logic             r_we;
    logic [RA_W-1:0]  r_rd;
    logic [XLEN-1:0]  r_din;
    logic [31:0]      r_busy;

    rr_arbiter #(
        .N_SRC (N_SRC)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (src_valid),
        .i_accept (w_hs),
        .o_grant  (w_grant)
    );

    assign src_ready = reset ? '0 : w_grant;
    assign w_hs      = |(src_valid & src_ready);

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = src_rd[i*RA_W +: RA_W];
                w_sel_data = src_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we  <= 1'b0;
            r_rd  <= '0;
            r_din <= '0;
        end else begin
            // x0 writes are consumed but never reach the register file.
            r_we <= w_hs && (w_sel_rd != '0);
            if (w_hs) begin
                r_rd  <= w_sel_rd;
                r_din <= w_sel_data;
            end
        end
    end

    assign rsv_ready = ~reset & ((rsv_rd == '0) | ~r_busy[rsv_rd]);
    assign w_set     = rsv_valid & rsv_ready & (rsv_rd != '0);

    // Reservation is applied after the writeback clear so a same-cycle set wins.
    always_comb begin
        w_busy_d = r_busy;
        if (r_we) begin
            w_busy_d[r_rd] = 1'b0;
        end
        if (w_set) begin
            w_busy_d[rsv_rd] = 1'b1;
        end
        w_busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    assign busy_vec = r_busy;
    assign q_stall  = r_busy[q_rs1] | r_busy[q_rs2];
    assign rf_we    = r_we;
    assign rf_rd    = r_rd;
    assign rf_din   = r_din;
endmodule
